// File: rtl/chipinvaders_pkg.sv
// chipinvaders_pkg
//   Shared types and screen constants for the chip-invaders playfield blocks.
//   march_state_t : alien march sequencer states (MARCH, CLEAR, HALT)
//   march_dir_t   : horizontal march direction (LEFT, RIGHT)
//   SCREEN_W/H    : visible playfield size in pixels
//   COORD_W       : width of pixel coordinates carried between blocks
package chipinvaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    MARCH = 2'd0,
    CLEAR = 2'd1,
    HALT  = 2'd2
  } march_state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } march_dir_t;

endpackage

// File: rtl/alien_mask_scan.sv
// alien_mask_scan
//   Combinational summary of the alien alive mask.
//   Ports:
//     i_alive_mask   in  NUM_ROWS*NUM_COLUMNS  bit r*NUM_COLUMNS+c = alien alive
//     o_alive_count  out 6  number of live aliens
//     o_lc           out 3  leftmost column holding a live alien
//     o_rc           out 3  rightmost column holding a live alien
//     o_lr           out 2  lowest (highest index) row holding a live alien
//   All column/row outputs read 0 when the mask is empty.
module alien_mask_scan #(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLUMNS = 4
) (
  input  logic [NUM_ROWS*NUM_COLUMNS-1:0] i_alive_mask,
  output logic [5:0]                      o_alive_count,
  output logic [2:0]                      o_lc,
  output logic [2:0]                      o_rc,
  output logic [1:0]                      o_lr
);

  logic [NUM_COLUMNS-1:0] w_col_alive;
  logic [NUM_ROWS-1:0]    w_row_alive;

  always_comb begin
    w_col_alive   = '0;
    w_row_alive   = '0;
    o_alive_count = '0;
    o_lc          = '0;
    o_rc          = '0;
    o_lr          = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLUMNS; c++) begin
        if (i_alive_mask[r*NUM_COLUMNS+c]) begin
          w_col_alive[c] = 1'b1;
          w_row_alive[r] = 1'b1;
          o_alive_count  = o_alive_count + 6'd1;
        end
      end
    end
    // Descending scan leaves the smallest live column; ascending scans
    // leave the largest live column and row.
    for (int c = NUM_COLUMNS-1; c >= 0; c--) begin
      if (w_col_alive[c]) o_lc = 3'(c);
    end
    for (int c = 0; c < NUM_COLUMNS; c++) begin
      if (w_col_alive[c]) o_rc = 3'(c);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (w_row_alive[r]) o_lr = 2'(r);
    end
  end

endmodule

// File: rtl/alien_march_controller.sv
// alien_march_controller
//   Steps the alien formation origin once every `period` frames, descending
//   and reversing at the screen edges, and flags wave-clear / invasion.
//   Optional build macro: ALIEN_MARCH_SPEEDUP_EN -- when defined, the step
//   period shrinks by SPEEDUP frames per dead alien (floor MIN_PERIOD);
//   when undefined the period is fixed at BASE_PERIOD.
//   Ports:
//     clk            in   pixel clock
//     reset          in   asynchronous, active-high
//     frame_tick     in   one-clk pulse per frame
//     enable         in   game running; frame_tick ignored when low
//     restart        in   one-clk pulse: reload start state (wins over tick)
//     alive_mask     in   bit r*NUM_COLUMNS+c = alien alive
//     formation_x/y  out  formation origin (10 bit)
//     anim_frame     out  sprite frame, toggles every step
//     step_pulse     out  one-clk pulse per step/descend
//     wave_clear     out  sticky: all aliens dead
//     reached_bottom out  sticky: formation reached BOTTOM_LIMIT
module alien_march_controller
  import chipinvaders_pkg::*;
#(
  parameter int NUM_ROWS     = 2,
  parameter int NUM_COLUMNS  = 4,
  parameter int SPACING_X    = 64,
  parameter int SPACING_Y    = 32,
  parameter int ALIEN_W      = 32,
  parameter int ALIEN_H      = 16,
  parameter int START_X      = 100,
  parameter int START_Y      = 50,
  parameter int STEP_X       = 4,
  parameter int STEP_Y       = 8,
  parameter int LEFT_LIMIT   = 8,
  parameter int RIGHT_LIMIT  = 632,
  parameter int BOTTOM_LIMIT = 400,
  parameter int BASE_PERIOD  = 32,
  parameter int MIN_PERIOD   = 2,
  parameter int SPEEDUP      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          enable,
  input  logic                          restart,
  input  logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_mask,
  output logic [COORD_W-1:0]            formation_x,
  output logic [COORD_W-1:0]            formation_y,
  output logic                          anim_frame,
  output logic                          step_pulse,
  output logic                          wave_clear,
  output logic                          reached_bottom
);

  localparam int NUM_ALIENS = NUM_ROWS * NUM_COLUMNS;

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  march_dir_t         r_dir;
  march_state_t       r_state;
  logic               r_anim;
  logic               r_step;
  logic               r_wave;
  logic               r_bottom;
  logic [5:0]         r_frame_cnt;

  logic [5:0]         w_alive_count;
  logic [2:0]         w_lc;
  logic [2:0]         w_rc;
  logic [1:0]         w_lr;
  logic [6:0]         w_period;
  logic [6:0]         w_cnt_next;
  logic               w_step_due;
  logic [11:0]        w_right_edge;
  logic [11:0]        w_left_edge;
  logic [11:0]        w_bottom_edge;
  logic [COORD_W-1:0] w_y_desc;
  logic               w_hit_right;
  logic               w_hit_left;
  logic               w_hit_bottom;
  logic               w_descend;

  alien_mask_scan #(
    .NUM_ROWS    (NUM_ROWS),
    .NUM_COLUMNS (NUM_COLUMNS)
  ) u_scan (
    .i_alive_mask  (alive_mask),
    .o_alive_count (w_alive_count),
    .o_lc          (w_lc),
    .o_rc          (w_rc),
    .o_lr          (w_lr)
  );

`ifdef ALIEN_MARCH_SPEEDUP_EN
  function automatic logic [6:0] sat_period(input logic signed [6:0] raw);
    if (raw < $signed(7'(MIN_PERIOD))) return 7'(MIN_PERIOD);
    return $unsigned(raw);
  endfunction

  logic [5:0]         w_dead_cnt;
  logic [11:0]        w_penalty;
  logic signed [6:0]  w_pen_s;
  logic signed [6:0]  w_period_raw;

  assign w_dead_cnt   = 6'(NUM_ALIENS) - w_alive_count;
  assign w_penalty    = 12'(w_dead_cnt) * 12'(SPEEDUP);
  // Clamp the penalty so the 7-bit signed difference can never wrap.
  assign w_pen_s      = (w_penalty > 12'd63) ? 7'sd63 : $signed(w_penalty[6:0]);
  assign w_period_raw = $signed(7'(BASE_PERIOD)) - w_pen_s;
  assign w_period     = sat_period(w_period_raw);
`else
  assign w_period     = 7'(BASE_PERIOD);
`endif

  assign w_cnt_next = {1'b0, r_frame_cnt} + 7'd1;
  assign w_step_due = (w_cnt_next >= w_period);

  // Edge tests in 12 bits so origin + column offsets never overflow.
  assign w_right_edge  = 12'(r_x) + 12'(STEP_X) + 12'(w_rc) * 12'(SPACING_X) + 12'(ALIEN_W);
  assign w_hit_right   = (w_right_edge > 12'(RIGHT_LIMIT));
  assign w_left_edge   = 12'(r_x) + 12'(w_lc) * 12'(SPACING_X);
  // The origin itself must also stay >= 0 so x - STEP_X cannot wrap.
  assign w_hit_left    = (w_left_edge < 12'(LEFT_LIMIT + STEP_X)) || (r_x < COORD_W'(STEP_X));
  assign w_y_desc      = r_y + COORD_W'(STEP_Y);
  assign w_bottom_edge = 12'(w_y_desc) + 12'(w_lr) * 12'(SPACING_Y) + 12'(ALIEN_H);
  assign w_hit_bottom  = (w_bottom_edge >= 12'(BOTTOM_LIMIT));
  assign w_descend     = (r_dir == RIGHT) ? w_hit_right : w_hit_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x         <= COORD_W'(START_X);
      r_y         <= COORD_W'(START_Y);
      r_dir       <= RIGHT;
      r_state     <= MARCH;
      r_anim      <= 1'b0;
      r_step      <= 1'b0;
      r_wave      <= 1'b0;
      r_bottom    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_step <= 1'b0;
      if (restart) begin
        r_x         <= COORD_W'(START_X);
        r_y         <= COORD_W'(START_Y);
        r_dir       <= RIGHT;
        r_state     <= MARCH;
        r_anim      <= 1'b0;
        r_wave      <= 1'b0;
        r_bottom    <= 1'b0;
        r_frame_cnt <= '0;
      end else if (frame_tick && enable && (r_state == MARCH)) begin
        if (w_alive_count == 6'd0) begin
          r_state <= CLEAR;
          r_wave  <= 1'b1;
        end else if (w_step_due) begin
          r_frame_cnt <= '0;
          r_step      <= 1'b1;
          r_anim      <= ~r_anim;
          if (w_descend) begin
            r_y   <= w_y_desc;
            r_dir <= (r_dir == RIGHT) ? LEFT : RIGHT;
            if (w_hit_bottom) begin
              r_state  <= HALT;
              r_bottom <= 1'b1;
            end
          end else if (r_dir == RIGHT) begin
            r_x <= r_x + COORD_W'(STEP_X);
          end else begin
            r_x <= r_x - COORD_W'(STEP_X);
          end
        end else begin
          r_frame_cnt <= w_cnt_next[5:0];
        end
      end
    end
  end

  assign formation_x    = r_x;
  assign formation_y    = r_y;
  assign anim_frame     = r_anim;
  assign step_pulse     = r_step;
  assign wave_clear     = r_wave;
  assign reached_bottom = r_bottom;

endmodule

// File: tb/tb_alien_march_controller.sv
// tb_alien_march_controller
//   Directed bench for alien_march_controller. A second instance with a
//   raised invasion line (BOTTOM_LIMIT=106) shares all inputs so that the
//   first descend of the main march also exercises the HALT path.
module tb_alien_march_controller;

`ifdef ALIEN_MARCH_SPEEDUP_EN
  localparam int P_ONE  = 11;  // 7 dead: 32 - 21
  localparam int P_COL3 = 26;  // 2 dead: 32 - 6
`else
  localparam int P_ONE  = 32;
  localparam int P_COL3 = 32;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic       restart;
  logic [7:0] alive_mask;

  logic [9:0] fx, fy, fx_b, fy_b;
  logic       anim, sp, wc, rb;
  logic       anim_b, sp_b, wc_b, rb_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alien_march_controller u_dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .enable         (enable),
    .restart        (restart),
    .alive_mask     (alive_mask),
    .formation_x    (fx),
    .formation_y    (fy),
    .anim_frame     (anim),
    .step_pulse     (sp),
    .wave_clear     (wc),
    .reached_bottom (rb)
  );

  alien_march_controller #(.BOTTOM_LIMIT(106)) u_dut_b (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .enable         (enable),
    .restart        (restart),
    .alive_mask     (alive_mask),
    .formation_x    (fx_b),
    .formation_y    (fy_b),
    .anim_frame     (anim_b),
    .step_pulse     (sp_b),
    .wave_clear     (wc_b),
    .reached_bottom (rb_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame strobe; returns the step_pulse produced by it.
  task automatic tick(output logic stepped);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    stepped = sp;
  endtask

  // Ticks until a step is seen; n = ticks used, 0 if none within limit.
  task automatic ticks_to_step(input int limit, output int n);
    logic s;
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      tick(s);
      if (s) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    logic s;
    int   n;
    int   cnt;

    reset      = 1'b1;
    frame_tick = 1'b0;
    enable     = 1'b1;
    restart    = 1'b0;
    alive_mask = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_x", fx, 100);
    check("rst_y", fy, 50);
    check("rst_anim", anim, 0);
    check("rst_step", sp, 0);
    check("rst_wave", wc, 0);
    check("rst_bottom", rb, 0);
    reset = 1'b0;

    // Full formation: first step on tick 32
    cnt = 0;
    for (int i = 0; i < 31; i++) begin
      tick(s);
      if (s) cnt++;
    end
    check("no_step_ticks_1_31", cnt, 0);
    tick(s);
    check("step_on_tick_32", s, 1);
    check("x_after_step1", fx, 104);
    check("anim_after_step1", anim, 1);
    @(negedge clk);
    check("step_pulse_one_clk", sp, 0);

    // Steps 2..77 march right to x=408
    cnt = 0;
    for (int k = 2; k <= 77; k++) begin
      ticks_to_step(40, n);
      if (n == 32) cnt++;
    end
    check("steps_2_77_period32", cnt, 76);
    check("x_after_step77", fx, 408);
    check("y_after_step77", fy, 50);
    check("anim_after_step77", anim, 1);

    // Step 78 hits the right edge and descends
    ticks_to_step(40, n);
    check("step78_ticks", n, 32);
    check("x_after_descend", fx, 408);
    check("y_after_descend", fy, 58);
    check("anim_after_descend", anim, 0);
    check("main_not_bottom", rb, 0);
    check("b_reached_bottom", rb_b, 1);
    check("b_y_descend", fy_b, 58);

    // Direction now LEFT; the halted instance stays frozen
    ticks_to_step(40, n);
    check("x_after_left_step", fx, 404);
    check("y_after_left_step", fy, 58);
    check("b_halt_x", fx_b, 408);
    check("b_halt_y", fy_b, 58);

    // Enable low freezes the frame counter
    for (int i = 0; i < 5; i++) tick(s);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(s);
      if (s) cnt++;
    end
    check("disabled_no_steps", cnt, 0);
    check("disabled_x_held", fx, 404);
    enable = 1'b1;
    ticks_to_step(40, n);
    check("resume_ticks_27", n, 27);
    check("x_after_resume", fx, 400);

    // Restart coincident with a tick that would step
    for (int i = 0; i < 31; i++) tick(s);
    @(negedge clk);
    frame_tick = 1'b1;
    restart    = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    restart    = 1'b0;
    check("restart_no_step", sp, 0);
    check("restart_x", fx, 100);
    check("restart_y", fy, 50);
    check("restart_anim", anim, 0);
    check("b_restart_bottom", rb_b, 0);
    check("b_restart_y", fy_b, 50);
    ticks_to_step(40, n);
    check("restart_period", n, 32);
    check("restart_first_x", fx, 104);

    // Single survivor at row 0 column 0
    alive_mask = 8'h01;
    ticks_to_step(40, n);
    check("one_alive_period", n, P_ONE);
    check("one_alive_x", fx, 108);

    // Column 3 empty: right edge narrows
    alive_mask = 8'h77;
    ticks_to_step(40, n);
    check("col3_dead_period", n, P_COL3);
    check("col3_first_x", fx, 112);
    cnt = 0;
    for (int k = 0; k < 90; k++) begin
      ticks_to_step(40, n);
      if (n == P_COL3) cnt++;
    end
    check("col3_march_steps", cnt, 90);
    check("col3_last_x", fx, 472);
    check("col3_last_y", fy, 50);
    ticks_to_step(40, n);
    check("col3_descend_x", fx, 472);
    check("col3_descend_y", fy, 58);

    // Wave clear
    alive_mask = 8'h00;
    tick(s);
    check("clear_no_step", s, 0);
    check("clear_flag", wc, 1);
    check("clear_x", fx, 472);
    check("clear_y", fy, 58);
    alive_mask = 8'hFF;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(s);
      if (s) cnt++;
    end
    check("clear_ignores_ticks", cnt, 0);
    check("clear_sticky", wc, 1);

    // Asynchronous reset while step_pulse is high
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_clears_wave", wc, 0);
    for (int i = 0; i < 31; i++) tick(s);
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_step", sp, 1);
    check("pre_reset_x", fx, 104);
    #1 reset = 1'b1;
    #1;
    check("async_rst_step", sp, 0);
    check("async_rst_x", fx, 100);
    check("async_rst_anim", anim, 0);
    @(negedge clk);
    frame_tick = 1'b0;
    reset      = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alien_march_controller.md
Name: alien_march_controller

Overview:
Sequences the alien formation's march across the playfield. Once per frame strobe it counts frames, steps the formation origin left or right, descends and reverses at screen edges, and speeds up as aliens die. Reports wave-clear and reached-bottom to game control. Sits between the VGA timing generator (frame strobe) and alien_formation, which draws at the origin this block supplies.

Parameters:
NUM_ROWS, 2, formation rows (1..4)
NUM_COLUMNS, 4, formation columns (1..8)
SPACING_X, 64, column pitch in pixels
SPACING_Y, 32, row pitch in pixels
ALIEN_W, 32, sprite width; ALIEN_H, 16, sprite height
START_X, 100, reset/restart origin x; START_Y, 50, reset/restart origin y
STEP_X, 4, horizontal pixels per step; STEP_Y, 8, pixels per descend
LEFT_LIMIT, 8, leftmost allowed sprite pixel; RIGHT_LIMIT, 632, rightmost allowed pixel
BOTTOM_LIMIT, 400, invasion line y
BASE_PERIOD, 32, frames per step with all alive (<=63); MIN_PERIOD, 2; SPEEDUP, 3, frames removed per dead alien

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high
frame_tick  in  1  one-clk pulse per frame
enable  in  1  game running; frame_tick ignored when 0
restart  in  1  one-clk pulse: reload start state
alive_mask  in  NUM_ROWS*NUM_COLUMNS  bit r*NUM_COLUMNS+c = alien alive
formation_x  out  10  origin x (alien_formation origin)
formation_y  out  10  origin y
anim_frame  out  1  sprite frame, toggles each step
step_pulse  out  1  one-clk pulse when a step/descend is taken
wave_clear  out  1  sticky: all aliens dead
reached_bottom  out  1  sticky: formation hit BOTTOM_LIMIT

Behaviour:
- Reset/restart: x=START_X, y=START_Y, dir=RIGHT, anim_frame=0, step_pulse=0, frame_cnt=0, flags=0, state=MARCH. Restart wins over simultaneous frame_tick.
- States: MARCH, CLEAR, HALT. CLEAR/HALT ignore frame_tick; leave only on reset/restart.
- Derived from alive_mask at the tick: alive_count, leftmost/rightmost alive column (lc, rc), lowest alive row (lr).
- period = max(MIN_PERIOD, BASE_PERIOD - (NUM_ROWS*NUM_COLUMNS - alive_count)*SPEEDUP), 7-bit signed intermediate, saturates at MIN_PERIOD.
- MARCH on frame_tick && enable:
  - alive_count==0 -> CLEAR, wave_clear=1, no step.
  - else frame_cnt+1 >= period -> step, frame_cnt=0; otherwise frame_cnt++.
- Step, dir RIGHT: if x+STEP_X+rc*SPACING_X+ALIEN_W > RIGHT_LIMIT -> descend; else x+=STEP_X.
- Step, dir LEFT: if x+lc*SPACING_X < LEFT_LIMIT+STEP_X -> descend; else x-=STEP_X. No 10-bit underflow.
- Descend: y+=STEP_Y, dir flips, x unchanged. If y_new+lr*SPACING_Y+ALIEN_H >= BOTTOM_LIMIT -> HALT, reached_bottom=1.
- Every step (march or descend): anim_frame toggles, step_pulse=1 for exactly one clk.
- Latency: all outputs registered; updated on the clk edge after frame_tick is sampled.
- alive_mask sampled only on the frame_tick cycle.
- A shrinking mask mid-march narrows the edge test immediately. Periods are recomputed each tick; frame_cnt >= new period steps on that tick.
- enable deassert freezes all state; reasserting resumes, frame_cnt preserved.

Optional Feature:
ALIEN_MARCH_SPEEDUP_EN: defined -> period formula above. Undefined -> period fixed at BASE_PERIOD, and the alive-count speedup logic is not built. alive_count is still used for wave-clear.

Decomposition:
- chipinvaders_pkg: march_state_t enum (MARCH, CLEAR, HALT), march_dir_t enum (LEFT, RIGHT), screen constants (640x480, coordinate width 10).
- One sub-module, alien_mask_scan: combinational. Takes alive_mask; returns alive_count, lc, rc, lr.

Test Plan:
- All alive, enable=1, 32 ticks -> one step_pulse on tick 32: x=104, anim_frame=1. Ticks 1-31 produce no step.
- All alive, run 78 steps -> steps 1-77 end at x=408. Step 78 descends: y=58, x=408, dir=LEFT.
- alive_mask=8'b0000_0001 (macro on) -> step every 11 ticks. Macro off -> every 32.
- Column 3 dead (mask 8'b0111_0111) -> right descend when x+4+128+32>632. Last x=472, descend on the next step. Period 26.
- alive_mask=0 at tick -> wave_clear=1, no further steps. Restart pulse coincident with frame_tick -> x=100, y=50, flags=0, no step_pulse.
- Force y near limit: after descend, y+32+16>=400 -> reached_bottom=1, HALT. Later ticks leave x/y unchanged. Async reset mid-step -> outputs to reset values at once.
